// File: rtl/image_rom_reader.sv
// Image ROM read-side initiator: maps the beam position to an image ROM address,
// waits out the ROM's registered read and overlays the returned colour on the stream.
module image_rom_reader #(
  parameter int                    ADDR_WIDTH  = 20,
  parameter int                    DATA_WIDTH  = 12,
  parameter int                    IMG_WIDTH   = 1024,
  parameter int                    IMG_HEIGHT  = 768,
  parameter int                    CNT_WIDTH   = 11,
  parameter logic [DATA_WIDTH-1:0] TRANSPARENT = 12'hF0F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [CNT_WIDTH-1:0]  x_pos,
  input  logic [CNT_WIDTH-1:0]  y_pos,
  input  logic [CNT_WIDTH-1:0]  hcount_in,
  input  logic [CNT_WIDTH-1:0]  vcount_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  hblnk_in,
  input  logic                  vblnk_in,
  input  logic [DATA_WIDTH-1:0] rgb_in,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [CNT_WIDTH-1:0]  hcount_out,
  output logic [CNT_WIDTH-1:0]  vcount_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  hblnk_out,
  output logic                  vblnk_out,
  output logic [DATA_WIDTH-1:0] rgb_out
);

  localparam int EXT_WIDTH = CNT_WIDTH + 1;

  typedef struct packed {
    logic [CNT_WIDTH-1:0]  hcount;
    logic [CNT_WIDTH-1:0]  vcount;
    logic                  hsync;
    logic                  vsync;
    logic                  hblnk;
    logic                  vblnk;
    logic [DATA_WIDTH-1:0] rgb;
    logic                  in_img;
  } stage_t;

  logic [CNT_WIDTH-1:0]  x_lat, y_lat;
  logic                  frame_start;
  logic [EXT_WIDTH-1:0]  x_end, y_end;
  logic                  hit_x, hit_y, in_img;
  logic [CNT_WIDTH-1:0]  dx, dy;
  logic [ADDR_WIDTH-1:0] addr_calc;
  stage_t                s1_next, s1, s2;
  logic [DATA_WIDTH-1:0] rgb_next;

  assign frame_start = (hcount_in == '0) && (vcount_in == '0);

  // Bounds use one extra bit so an image hanging past the counter range does not wrap.
  assign x_end = {1'b0, x_lat} + EXT_WIDTH'(IMG_WIDTH);
  assign y_end = {1'b0, y_lat} + EXT_WIDTH'(IMG_HEIGHT);
  assign hit_x = ({1'b0, hcount_in} >= {1'b0, x_lat}) && ({1'b0, hcount_in} < x_end);
  assign hit_y = ({1'b0, vcount_in} >= {1'b0, y_lat}) && ({1'b0, vcount_in} < y_end);
  assign in_img = enable && hit_x && hit_y;

  assign dx = hcount_in - x_lat;
  assign dy = vcount_in - y_lat;
  assign addr_calc = ADDR_WIDTH'(dy) * ADDR_WIDTH'(IMG_WIDTH) + ADDR_WIDTH'(dx);

  always_comb begin
    s1_next        = '0;
    s1_next.hcount = hcount_in;
    s1_next.vcount = vcount_in;
    s1_next.hsync  = hsync_in;
    s1_next.vsync  = vsync_in;
    s1_next.hblnk  = hblnk_in;
    s1_next.vblnk  = vblnk_in;
    s1_next.rgb    = rgb_in;
    s1_next.in_img = in_img;
  end

  // Position is only taken at frame start so a moving sprite never tears mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_lat <= '0;
      y_lat <= '0;
    end else if (frame_start) begin
      x_lat <= x_pos;
      y_lat <= y_pos;
    end
  end

  // NOTE: every clocked register uses <= so all stages sample the pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      rom_addr <= '0;
    end else begin
      s1       <= s1_next;
      s2       <= s1;
      rom_addr <= in_img ? addr_calc : '0;
    end
  end

  // rom_data here answers the address issued one cycle earlier, aligned with s2.
  always_comb begin
    rgb_next = s2.rgb;
    if (s2.hblnk || s2.vblnk) begin
      rgb_next = '0;
    end else if (s2.in_img && (rom_data != TRANSPARENT)) begin
      rgb_next = rom_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= s2.hcount;
      vcount_out <= s2.vcount;
      hsync_out  <= s2.hsync;
      vsync_out  <= s2.vsync;
      hblnk_out  <= s2.hblnk;
      vblnk_out  <= s2.vblnk;
      rgb_out    <= rgb_next;
    end
  end

endmodule

// File: tb/tb_image_rom_reader.sv
// Directed bench for image_rom_reader: a 64x64 instance for placement/transparency/latch
// cases and a full-screen 1024x768 instance for address and exact-latency cases.
module tb_image_rom_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [10:0] x_pos, y_pos, x_zero, y_zero;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;

  logic [19:0] rom_addr_s, rom_addr_f;
  logic [11:0] rom_data_s, rom_data_f;
  logic [10:0] hcount_out_s, vcount_out_s, hcount_out_f, vcount_out_f;
  logic        hsync_out_s, vsync_out_s, hblnk_out_s, vblnk_out_s;
  logic        hsync_out_f, vsync_out_f, hblnk_out_f, vblnk_out_f;
  logic [11:0] rgb_out_s, rgb_out_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  image_rom_reader #(.IMG_WIDTH(64), .IMG_HEIGHT(64)) dut (
    .clk(clk), .rst(rst), .enable(enable), .x_pos(x_pos), .y_pos(y_pos),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .rom_addr(rom_addr_s), .rom_data(rom_data_s),
    .hcount_out(hcount_out_s), .vcount_out(vcount_out_s), .hsync_out(hsync_out_s),
    .vsync_out(vsync_out_s), .hblnk_out(hblnk_out_s), .vblnk_out(vblnk_out_s),
    .rgb_out(rgb_out_s)
  );

  image_rom_reader dut_full (
    .clk(clk), .rst(rst), .enable(enable), .x_pos(x_zero), .y_pos(y_zero),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .rom_addr(rom_addr_f), .rom_data(rom_data_f),
    .hcount_out(hcount_out_f), .vcount_out(vcount_out_f), .hsync_out(hsync_out_f),
    .vsync_out(vsync_out_f), .hblnk_out(hblnk_out_f), .vblnk_out(vblnk_out_f),
    .rgb_out(rgb_out_f)
  );

  // ROM models: word = addr[11:0], with one planted 12'hABC word in the small image.
  always_ff @(posedge clk) begin
    rom_data_s <= (rom_addr_s == 20'd3856) ? 12'hABC : rom_addr_s[11:0];
    rom_data_f <= rom_addr_f[11:0];
  end

  typedef struct {
    logic        en;
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic [19:0] exp_addr;
    logic [11:0] exp_rgb;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [10:0] h, input logic [10:0] v,
                       input logic hs, input logic vs, input logic hb, input logic vb,
                       input logic [11:0] rgb);
    enable    = en;
    hcount_in = h;
    vcount_in = v;
    hsync_in  = hs;
    vsync_in  = vs;
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = rgb;
  endtask

  task automatic frame_start();
    drive(1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00F);
    step();
  endtask

  // Holds one pixel on the small instance; address after 1 edge, colour after 3.
  task automatic run_pix(input string name, input logic [10:0] h, input logic [10:0] v,
                         input logic [19:0] exp_addr, input logic [11:0] exp_rgb);
    drive(1'b1, h, v, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00F);
    step();
    check({name, "_addr"}, rom_addr_s, exp_addr);
    step();
    step();
    check({name, "_rgb"}, rgb_out_s, exp_rgb);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b1, 11'd99,  11'd50,  1'b0, 1'b0, 1'b0, 1'b0, 12'h00F, 20'd0,    12'h00F};
    vecs[1]  = '{1'b1, 11'd100, 11'd50,  1'b1, 1'b0, 1'b0, 1'b0, 12'h00F, 20'd0,    12'h000};
    vecs[2]  = '{1'b1, 11'd163, 11'd113, 1'b0, 1'b1, 1'b0, 1'b0, 12'h00F, 20'd4095, 12'hFFF};
    vecs[3]  = '{1'b1, 11'd164, 11'd113, 1'b1, 1'b1, 1'b0, 1'b0, 12'h00F, 20'd0,    12'h00F};
    vecs[4]  = '{1'b1, 11'd100, 11'd49,  1'b0, 1'b0, 1'b0, 1'b0, 12'h00F, 20'd0,    12'h00F};
    vecs[5]  = '{1'b1, 11'd100, 11'd114, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00F, 20'd0,    12'h00F};
    vecs[6]  = '{1'b1, 11'd101, 11'd51,  1'b0, 1'b0, 1'b1, 1'b0, 12'h00F, 20'd65,   12'h000};
    vecs[7]  = '{1'b1, 11'd101, 11'd51,  1'b0, 1'b0, 1'b0, 1'b1, 12'h00F, 20'd65,   12'h000};
    vecs[8]  = '{1'b0, 11'd101, 11'd51,  1'b0, 1'b0, 1'b0, 1'b0, 12'h00F, 20'd0,    12'h00F};
    vecs[9]  = '{1'b1, 11'd115, 11'd110, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 20'd3855, 12'h123};
    vecs[10] = '{1'b1, 11'd116, 11'd110, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 20'd3856, 12'hABC};

    x_zero = '0;
    y_zero = '0;
    x_pos  = '0;
    y_pos  = '0;

    // Reset with random inputs.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 11'($urandom), 11'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 12'($urandom));
      step();
    end
    check("rst_rom_addr", rom_addr_s, 0);
    check("rst_rom_addr_full", rom_addr_f, 0);
    check("rst_rgb", rgb_out_s, 0);
    check("rst_timing", {hcount_out_s, vcount_out_s, hsync_out_s, vsync_out_s,
                         hblnk_out_s, vblnk_out_s}, 0);

    rst = 1'b0;
    drive(1'b0, 11'd300, 11'd300, 1'b0, 1'b0, 1'b0, 1'b0, 12'h3C5);
    step();
    step();
    check("post_rst_edge2_rgb", rgb_out_s, 0);
    step();
    check("post_rst_edge3_rgb", rgb_out_s, 12'h3C5);

    // Full-screen image at (0,0).
    drive(1'b1, 11'd5, 11'd2, 1'b1, 1'b0, 1'b0, 1'b0, 12'h111);
    step();
    check("full_addr", rom_addr_f, 20'd2053);
    step();
    step();
    check("full_rgb", rgb_out_f, 12'h805);

    // Streaming: one different pixel per clock, enable dropped at i=5, hblnk at i=7.
    for (int i = 0; i < 10; i++) begin
      drive(i != 5, 11'(10 + i), 11'd2, i[0], i[1], i == 7, i == 9, 12'h111);
      step();
      check($sformatf("stream%0d_addr", i), rom_addr_f, (i != 5) ? 2048 + 10 + i : 0);
      if (i >= 2) begin
        int j;
        j = i - 2;
        check($sformatf("stream%0d_hcount", j), hcount_out_f, 10 + j);
        check($sformatf("stream%0d_vcount", j), vcount_out_f, 2);
        check($sformatf("stream%0d_sync", j), {hsync_out_f, vsync_out_f}, {j[0], j[1]});
        check($sformatf("stream%0d_blnk", j), {hblnk_out_f, vblnk_out_f}, {j == 7, j == 9});
        check($sformatf("stream%0d_rgb", j), rgb_out_f,
              (j == 7 || j == 9) ? 12'h000 : (j == 5) ? 12'h111 : 12'h800 + 12'(10 + j));
      end
    end

    // Offset 64x64 image at (100,50): table-driven.
    x_pos = 11'd100;
    y_pos = 11'd50;
    frame_start();
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].en, vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, vecs[i].hb,
            vecs[i].vb, vecs[i].rgb);
      step();
      check($sformatf("vec%0d_addr", i), rom_addr_s, vecs[i].exp_addr);
      step();
      step();
      check($sformatf("vec%0d_rgb", i), rgb_out_s, vecs[i].exp_rgb);
      check($sformatf("vec%0d_timing", i),
            {hcount_out_s, vcount_out_s, hsync_out_s, vsync_out_s, hblnk_out_s, vblnk_out_s},
            {vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, vecs[i].hb, vecs[i].vb});
    end

    // Mid-frame position change takes effect only at the next frame start.
    x_pos = 11'd200;
    run_pix("latch_old", 11'd100, 11'd50, 20'd0, 12'h000);
    frame_start();
    run_pix("latch_new", 11'd200, 11'd50, 20'd0, 12'h000);
    run_pix("latch_gone", 11'd100, 11'd50, 20'd0, 12'h00F);

    // Reset mid-frame returns the image to (0,0) until the next frame start.
    drive(1'b1, 11'd250, 11'd300, 1'b1, 1'b1, 1'b0, 1'b0, 12'h00F);
    rst = 1'b1;
    step();
    check("midrst_rgb", rgb_out_s, 0);
    check("midrst_addr", rom_addr_s, 0);
    check("midrst_hcount", hcount_out_s, 0);
    rst = 1'b0;
    run_pix("midrst_origin", 11'd10, 11'd10, 20'd650, 12'h28A);
    run_pix("midrst_old_pos", 11'd200, 11'd50, 20'd0, 12'h00F);
    x_pos = 11'd0;
    y_pos = 11'd0;
    frame_start();
    run_pix("redraw_origin", 11'd10, 11'd10, 20'd650, 12'h28A);

    // Partially off-screen image and a latch near the top of the counter range.
    x_pos = 11'd1000;
    y_pos = 11'd700;
    frame_start();
    run_pix("edge_right", 11'd1023, 11'd700, 20'd23, 12'h017);
    run_pix("edge_bottom", 11'd1000, 11'd763, 20'd4032, 12'hFC0);
    run_pix("edge_left_out", 11'd999, 11'd700, 20'd0, 12'h00F);
    x_pos = 11'd2040;
    frame_start();
    run_pix("nowrap_in", 11'd2045, 11'd700, 20'd5, 12'h005);
    run_pix("nowrap_out", 11'd3, 11'd700, 20'd0, 12'h00F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_rom_reader.md
Name: image_rom_reader

Overview:
- Read-side initiator for the synchronous single-port image ROMs (start, win, lose screens, sprites).
- Takes the VGA timing stream, computes the ROM address of the pixel under the beam, and waits out the ROM's 1-cycle registered read.
- Overlays the returned colour onto the incoming RGB and emits the timing stream delayed to stay aligned.
- Sits in the draw pipeline between the timing generator, or the previous draw stage, and the VGA output register.

Parameters:
ADDR_WIDTH, 20, ROM address width; must match the attached ROM.
DATA_WIDTH, 12, ROM word / RGB width (4:4:4).
IMG_WIDTH, 1024, image width in pixels.
IMG_HEIGHT, 768, image height in pixels; IMG_WIDTH*IMG_HEIGHT <= 2**ADDR_WIDTH.
CNT_WIDTH, 11, hcount/vcount/position width.
TRANSPARENT, 12'hF0F, colour key; ROM words equal to it are not drawn.

Ports:
clk  in  1  pixel clock, posedge active
rst  in  1  synchronous reset, active-high
enable  in  1  draw enable, sampled per pixel
x_pos  in  CNT_WIDTH  image left edge, screen pixels
y_pos  in  CNT_WIDTH  image top edge, screen pixels
hcount_in  in  CNT_WIDTH  horizontal pixel counter
vcount_in  in  CNT_WIDTH  vertical line counter
hsync_in  in  1  horizontal sync
vsync_in  in  1  vertical sync
hblnk_in  in  1  horizontal blank
vblnk_in  in  1  vertical blank
rgb_in  in  DATA_WIDTH  background colour
rom_addr  out  ADDR_WIDTH  address to ROM (ROM addrA)
rom_data  in  DATA_WIDTH  ROM dout, valid 1 cycle after rom_addr
hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  same widths  timing delayed 3 cycles
rgb_out  out  DATA_WIDTH  composed pixel

Behaviour:
- Reset (rst=1 at posedge):
  - All outputs go to 0, including rom_addr.
  - All pipeline stages and in-image flags are cleared.
  - Latched position is set to (0,0).
- Position latch:
  - x_lat/y_lat <= x_pos/y_pos only on a cycle where hcount_in==0 and vcount_in==0.
  - Mid-frame position changes do not tear the image.
  - Position is held otherwise.
- Stage 1, cycle N+1:
  - in_img = enable && hcount_in >= x_lat && hcount_in < x_lat+IMG_WIDTH && vcount_in >= y_lat && vcount_in < y_lat+IMG_HEIGHT.
  - Bounds are compared at CNT_WIDTH+1 bits so x_lat+IMG_WIDTH does not wrap.
  - If in_img: rom_addr <= (vcount_in-y_lat)*IMG_WIDTH + (hcount_in-x_lat), truncated to ADDR_WIDTH. Otherwise rom_addr <= 0.
  - Timing signals, rgb_in and in_img are registered.
- Stage 2, cycle N+2:
  - rom_data is valid for the stage-1 address.
  - Timing, rgb and in_img advance one more register.
- Stage 3, cycle N+3, output registers:
  - If hblnk or vblnk (delayed): rgb_out <= 0.
  - Else if in_img && rom_data != TRANSPARENT: rgb_out <= rom_data, where rom_data is registered into stage 3 at the N+2 edge.
  - Else: rgb_out <= rgb_in, delayed.
  - Timing outputs equal the inputs from 3 cycles earlier.
- Total latency is exactly 3 clocks for every output. There is no throughput stall; one pixel is accepted per clock.
- Boundaries:
  - Image partially off-screen (x_lat+IMG_WIDTH beyond the active area): only on-screen pixels are drawn, and addresses stay correct for the visible part.
  - enable deasserted mid-line: the effect appears at the output 3 cycles later, on the pixel boundary.
  - Reset mid-frame: the pipeline flushes to 0. The first valid output is 3 cycles after rst deasserts. Position stays (0,0) until the next frame-start latch.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> all outputs 0 and rom_addr=0. After release, rgb_out follows rgb_in 3 cycles later with image disabled.
- Full-screen image at (0,0), ROM model with word = addr[11:0]:
  - hcount=5, vcount=2 -> rom_addr=2053 at N+1.
  - rgb_out=12'h805 at N+3.
  - hsync/vsync/blanks delayed exactly 3.
- Offset image at x_pos=100, y_pos=50, IMG 64x64, rgb_in=12'h00F:
  - (99,50) -> 12'h00F.
  - (100,50) -> ROM word 0.
  - (163,113) -> ROM word 4095.
  - (164,113) -> 12'h00F.
- Transparency: ROM returns 12'hF0F at in-image pixel with rgb_in=12'h123 -> rgb_out=12'h123. The next pixel returns 12'hABC -> 12'hABC.
- Blanking: hblnk_in=1 inside image area -> rgb_out=0 three cycles later, and rom_addr is still computed.
- Position latch: change x_pos 100->200 mid-frame -> the current frame keeps drawing at 100. After hcount=vcount=0 the image starts at 200. Assert rst at vcount=300 -> outputs 0 next cycle, and the image is redrawn at (0,0) after the following frame start.
